// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side bundle (two request ports plus shared result return).
// Latency: none, wires only.
// Backpressure: req is held by the requester until it sees its gnt pulse.
interface alu_arbiter_if #(
   parameter int WIDTH  = 16,
   parameter int CTRL_W = 4
);
   logic [1:0]        req;
   logic [CTRL_W-1:0] op0;
   logic [CTRL_W-1:0] op1;
   logic [WIDTH-1:0]  a0;
   logic [WIDTH-1:0]  a1;
   logic [WIDTH-1:0]  b0;
   logic [WIDTH-1:0]  b1;
   logic [1:0]        gnt;
   logic [1:0]        done;
   logic [WIDTH-1:0]  result;
   logic              ovf;
   logic              err;

   // Arbiter side
   modport slave (
      input  req, op0, op1, a0, a1, b0, b1,
      output gnt, done, result, ovf, err
   );

   // Requester side
   modport master (
      output req, op0, op1, a0, a1, b0, b1,
      input  gnt, done, result, ovf, err
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between two requesters; optional op legality check via ALU_ARB_OPCHECK_EN.
// Latency: gnt one cycle after req is sampled, done ALU_LAT+1 cycles after gnt; one op per ALU_LAT+2 cycles.
// Backpressure: no arbitration in BUSY/DONE; pending req waits (never lost) until the FSM is back in IDLE.
module alu_arbiter #(
   parameter int WIDTH   = 16,
   parameter int CTRL_W  = 4,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_arbiter_if.slave      rq,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [WIDTH-1:0]  alu_wd,
   input  logic              alu_ovf
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [3:0] LAT_CNT = 4'(ALU_LAT);

   state_t            state_q, state_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        done_q, done_d;
   logic              win_q, win_d;
   logic              rr_q, rr_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [WIDTH-1:0]  wd_q, wd_d;       // ALU result captured at end of BUSY
   logic              ovfp_q, ovfp_d;   // ALU overflow captured with wd_q
   logic [WIDTH-1:0]  result_q, result_d;
   logic              ovf_q, ovf_d;

   logic              win_sel;
   logic [CTRL_W-1:0] sel_op;
   logic [WIDTH-1:0]  sel_a;
   logic [WIDTH-1:0]  sel_b;

`ifdef ALU_ARB_OPCHECK_EN
   logic              illg_q, illg_d;   // latched op is not a supported ALU code
   logic              err_q, err_d;

   function automatic logic op_legal(input logic [CTRL_W-1:0] op);
      logic ok;
      ok = 1'b0;
      if (op == CTRL_W'(4'b0000) || op == CTRL_W'(4'b0001) ||
          op == CTRL_W'(4'b0010) || op == CTRL_W'(4'b0110) ||
          op == CTRL_W'(4'b0111) || op == CTRL_W'(4'b1100))
         ok = 1'b1;
      return ok;
   endfunction
`endif

   // Winner pick: a lone requester wins, contention goes to rr pointer
   always_comb begin
      unique case (rq.req)
         2'b01:   win_sel = 1'b0;
         2'b10:   win_sel = 1'b1;
         2'b11:   win_sel = rr_q;
         default: win_sel = 1'b0;
      endcase
   end

   assign sel_op = win_sel ? rq.op1 : rq.op0;
   assign sel_a  = win_sel ? rq.a1  : rq.a0;
   assign sel_b  = win_sel ? rq.b1  : rq.b0;

   // FSM next state: arbitrate in IDLE, count ALU latency in BUSY, pulse done in DONE
   always_comb begin
      state_d  = state_q;
      gnt_d    = 2'b00;
      done_d   = 2'b00;
      win_d    = win_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      ctrl_d   = ctrl_q;
      wd_d     = wd_q;
      ovfp_d   = ovfp_q;
      result_d = result_q;
      ovf_d    = ovf_q;
`ifdef ALU_ARB_OPCHECK_EN
      illg_d   = illg_q;
      err_d    = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (rq.req != 2'b00) begin
               gnt_d[win_sel] = 1'b1;
               win_d          = win_sel;
               rr_d           = ~win_sel;
               a_d            = sel_a;
               b_d            = sel_b;
`ifdef ALU_ARB_OPCHECK_EN
               // Illegal codes never reach the ALU; it sees a harmless AND
               illg_d         = ~op_legal(sel_op);
               ctrl_d         = op_legal(sel_op) ? sel_op : '0;
`else
               ctrl_d         = sel_op;
`endif
               cnt_d          = LAT_CNT;
               state_d        = BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
`ifdef ALU_ARB_OPCHECK_EN
               wd_d   = illg_q ? '0   : alu_wd;
               ovfp_d = illg_q ? 1'b0 : alu_ovf;
`else
               wd_d   = alu_wd;
               ovfp_d = alu_ovf;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            // result/ovf/err only change together with the done pulse
            done_d[win_q] = 1'b1;
            result_d      = wd_q;
            ovf_d         = ovfp_q;
`ifdef ALU_ARB_OPCHECK_EN
            err_d         = illg_q;
`endif
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset discards any in-flight op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= 2'b00;
         done_q   <= 2'b00;
         win_q    <= 1'b0;
         rr_q     <= 1'b0;
         cnt_q    <= 4'd0;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= '0;
         wd_q     <= '0;
         ovfp_q   <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
         illg_q   <= 1'b0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         win_q    <= win_d;
         rr_q     <= rr_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ctrl_q   <= ctrl_d;
         wd_q     <= wd_d;
         ovfp_q   <= ovfp_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
`ifdef ALU_ARB_OPCHECK_EN
         illg_q   <= illg_d;
         err_q    <= err_d;
`endif
      end
   end

   assign rq.gnt    = gnt_q;
   assign rq.done   = done_q;
   assign rq.result = result_q;
   assign rq.ovf    = ovf_q;
`ifdef ALU_ARB_OPCHECK_EN
   assign rq.err    = err_q;
`else
   assign rq.err    = 1'b0;
`endif
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_ctrl  = ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives two arbiter instances (ALU_LAT=1 and ALU_LAT=3) against a behavioural ALU.
// Latency: checks gnt/done on exact cycles relative to the request.
// Backpressure: requests held until gnt, then dropped or re-raised per scenario.
module tb_alu_arbiter;
   localparam int W = 16;
   localparam int C = 4;

   typedef struct {
      logic [1:0]   who;
      logic [W-1:0] res;
      logic         ovf;
      logic         err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   exp_t sb[$];

   alu_arbiter_if #(.WIDTH(W), .CTRL_W(C)) if1 ();
   alu_arbiter_if #(.WIDTH(W), .CTRL_W(C)) if3 ();

   logic [W-1:0] alu_a1, alu_b1, wd1, alu_a3, alu_b3, wd3;
   logic [C-1:0] ctrl1, ctrl3;
   logic         aovf1, aovf3;

   alu_arbiter #(.WIDTH(W), .CTRL_W(C), .ALU_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .rq(if1),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_ctrl(ctrl1),
      .alu_wd(wd1), .alu_ovf(aovf1)
   );

   alu_arbiter #(.WIDTH(W), .CTRL_W(C), .ALU_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .rq(if3),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_ctrl(ctrl3),
      .alu_wd(wd3), .alu_ovf(aovf3)
   );

   // Behavioural ALU: returns {overflow, write data}
   function automatic logic [W:0] alu_model(input logic [C-1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] s;
      logic         v;
      s = '0;
      v = 1'b0;
      case (c)
         4'b0000: s = a & b;
         4'b0001: s = a | b;
         4'b0010: begin s = a + b; v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]); end
         4'b0110: begin s = a - b; v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]); end
         4'b0111: s = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         4'b1100: s = ~(a | b);
         default: s = '0;
      endcase
      return {v, s};
   endfunction

   always_comb {aovf1, wd1} = alu_model(ctrl1, alu_a1, alu_b1);
   always_comb {aovf3, wd3} = alu_model(ctrl3, alu_a3, alu_b3);

   task automatic clear_inputs();
      if1.req = 2'b00; if1.op0 = '0; if1.op1 = '0;
      if1.a0 = '0; if1.a1 = '0; if1.b0 = '0; if1.b1 = '0;
      if3.req = 2'b00; if3.op0 = '0; if3.op1 = '0;
      if3.a0 = '0; if3.a1 = '0; if3.b0 = '0; if3.b1 = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [57:0] all1;
      logic [57:0] all3;
      logic        seen;
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      all1 = {if1.gnt, if1.done, if1.result, if1.ovf, if1.err, alu_a1, alu_b1, ctrl1};
      all3 = {if3.gnt, if3.done, if3.result, if3.ovf, if3.err, alu_a3, alu_b3, ctrl3};
      checks++;
      if (all1 !== 58'd0) $display("FAIL reset_state_lat1: got %h want 0", all1);
      else passed++;
      checks++;
      if (all3 !== 58'd0) $display("FAIL reset_state_lat3: got %h want 0", all3);
      else passed++;
      rst_n = 1'b1;
      @(negedge clk);
      // Start an op, then reset while it is in BUSY
      if1.req = 2'b01; if1.op0 = 4'b0010; if1.a0 = 16'h1234; if1.b0 = 16'h0001;
      @(negedge clk);
      checks++;
      if (if1.gnt !== 2'b01) $display("FAIL reset_pre_gnt: got %b want 01", if1.gnt);
      else passed++;
      if1.req = 2'b00;
      rst_n = 1'b0;
      #1;
      all1 = {if1.gnt, if1.done, if1.result, if1.ovf, if1.err, alu_a1, alu_b1, ctrl1};
      checks++;
      if (all1 !== 58'd0) $display("FAIL reset_mid_busy: got %h want 0", all1);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (if1.done !== 2'b00 || if1.gnt !== 2'b00) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) $display("FAIL reset_no_done: got activity=%b want 0", seen);
      else passed++;
   endtask

   task automatic test_add_ovf();
      exp_t e;
      if1.req = 2'b01; if1.op0 = 4'b0010; if1.a0 = 16'h7FFF; if1.b0 = 16'h0001;
      @(negedge clk);
      checks++;
      if (if1.gnt !== 2'b01) $display("FAIL add_gnt: got %b want 01", if1.gnt);
      else passed++;
      e.who = 2'b01; e.res = 16'h8000; e.ovf = 1'b1; e.err = 1'b0;
      sb.push_back(e);
      if1.req = 2'b00;
      @(negedge clk);
      checks++;
      if (if1.done !== 2'b00 || if1.gnt !== 2'b00) $display("FAIL add_early: got gnt=%b done=%b want 00/00", if1.gnt, if1.done);
      else passed++;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (if1.done !== e.who || if1.result !== e.res || if1.ovf !== e.ovf || if1.err !== e.err)
         $display("FAIL add_done: got done=%b res=%h ovf=%b err=%b want %b/%h/%b/%b",
                  if1.done, if1.result, if1.ovf, if1.err, e.who, e.res, e.ovf, e.err);
      else passed++;
      @(negedge clk);
      checks++;
      if (if1.done !== 2'b00 || if1.result !== 16'h8000)
         $display("FAIL add_pulse_hold: got done=%b res=%h want 00/8000", if1.done, if1.result);
      else passed++;
   endtask

   task automatic test_round_robin();
      do_reset();
      if1.req = 2'b11;
      if1.op0 = 4'b0000; if1.a0 = 16'h0F0F; if1.b0 = 16'hF0F0;
      if1.op1 = 4'b0001; if1.a1 = 16'h0F0F; if1.b1 = 16'hF0F0;
      for (int i = 0; i < 4; i++) begin
         exp_t        e;
         logic [1:0]  w;
         w = (i % 2 == 0) ? 2'b01 : 2'b10;
         @(negedge clk);
         checks++;
         if (if1.gnt !== w || if1.done !== 2'b00) $display("FAIL rr_gnt%0d: got gnt=%b done=%b want %b/00", i, if1.gnt, if1.done, w);
         else passed++;
         e.who = w; e.res = (w == 2'b01) ? 16'h0000 : 16'hFFFF; e.ovf = 1'b0; e.err = 1'b0;
         sb.push_back(e);
         @(negedge clk);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (if1.done !== e.who || if1.result !== e.res || if1.gnt !== 2'b00)
            $display("FAIL rr_done%0d: got done=%b res=%h gnt=%b want %b/%h/00", i, if1.done, if1.result, if1.gnt, e.who, e.res);
         else passed++;
      end
      if1.req = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_lat3();
      exp_t e;
      logic bad;
      if3.req = 2'b10; if3.op1 = 4'b0111; if3.a1 = 16'h0001; if3.b1 = 16'h0002;
      @(negedge clk);
      checks++;
      if (if3.gnt !== 2'b10) $display("FAIL lat3_gnt: got %b want 10", if3.gnt);
      else passed++;
      e.who = 2'b10; e.res = 16'h0001; e.ovf = 1'b0; e.err = 1'b0;
      sb.push_back(e);
      if3.req = 2'b00;
      @(negedge clk);
      if3.req = 2'b01; if3.op0 = 4'b0000; if3.a0 = 16'h00FF; if3.b0 = 16'h0F0F;
      bad = (if3.gnt !== 2'b00) || (if3.done !== 2'b00);
      @(negedge clk);
      bad = bad || (if3.gnt !== 2'b00) || (if3.done !== 2'b00);
      @(negedge clk);
      bad = bad || (if3.gnt !== 2'b00) || (if3.done !== 2'b00);
      checks++;
      if (bad !== 1'b0) $display("FAIL lat3_busy_quiet: got activity=%b want 0", bad);
      else passed++;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (if3.done !== e.who || if3.result !== e.res || if3.gnt !== 2'b00)
         $display("FAIL lat3_done: got done=%b res=%h gnt=%b want %b/%h/00", if3.done, if3.result, if3.gnt, e.who, e.res);
      else passed++;
      @(negedge clk);
      checks++;
      if (if3.gnt !== 2'b01) $display("FAIL lat3_wait_gnt: got %b want 01", if3.gnt);
      else passed++;
      e.who = 2'b01; e.res = 16'h000F; e.ovf = 1'b0; e.err = 1'b0;
      sb.push_back(e);
      if3.req = 2'b00;
      repeat (4) @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (if3.done !== e.who || if3.result !== e.res)
         $display("FAIL lat3_done2: got done=%b res=%h want %b/%h", if3.done, if3.result, e.who, e.res);
      else passed++;
   endtask

   task automatic test_sub_drop();
      exp_t e;
      logic bad;
      if1.req = 2'b01; if1.op0 = 4'b0110; if1.a0 = 16'h8000; if1.b0 = 16'h0001;
      @(negedge clk);
      checks++;
      if (if1.gnt !== 2'b01) $display("FAIL sub_gnt: got %b want 01", if1.gnt);
      else passed++;
      e.who = 2'b01; e.res = 16'h7FFF; e.ovf = 1'b1; e.err = 1'b0;
      sb.push_back(e);
      // Operands may change once the grant is seen
      if1.a0 = 16'h0000; if1.b0 = 16'h0000; if1.op0 = 4'b0001;
      @(negedge clk);
      if1.req = 2'b00;
      checks++;
      if (alu_a1 !== 16'h8000 || alu_b1 !== 16'h0001 || ctrl1 !== 4'b0110)
         $display("FAIL sub_latched: got a=%h b=%h c=%b want 8000/0001/0110", alu_a1, alu_b1, ctrl1);
      else passed++;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (if1.done !== e.who || if1.result !== e.res || if1.ovf !== e.ovf)
         $display("FAIL sub_done: got done=%b res=%h ovf=%b want %b/%h/%b", if1.done, if1.result, if1.ovf, e.who, e.res, e.ovf);
      else passed++;
      // A request pulse that never spans a rising edge has no effect
      @(negedge clk);
      if1.req = 2'b10;
      #2;
      if1.req = 2'b00;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (if1.gnt !== 2'b00 || if1.done !== 2'b00) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) $display("FAIL drop_before_gnt: got activity=%b want 0", bad);
      else passed++;
   endtask

   task automatic test_opcheck();
      exp_t e;
      if1.req = 2'b01; if1.op0 = 4'b0011; if1.a0 = 16'h1234; if1.b0 = 16'h0F0F;
      @(negedge clk);
      checks++;
      if (if1.gnt !== 2'b01) $display("FAIL opchk_gnt: got %b want 01", if1.gnt);
      else passed++;
`ifdef ALU_ARB_OPCHECK_EN
      e.who = 2'b01; e.res = 16'h0000; e.ovf = 1'b0; e.err = 1'b1;
      checks++;
      if (ctrl1 !== 4'b0000 || alu_a1 !== 16'h1234)
         $display("FAIL opchk_ctrl: got c=%b a=%h want 0000/1234", ctrl1, alu_a1);
      else passed++;
`else
      e.who = 2'b01; e.res = 16'h0000; e.ovf = 1'b0; e.err = 1'b0;
      checks++;
      if (ctrl1 !== 4'b0011 || alu_a1 !== 16'h1234)
         $display("FAIL opchk_ctrl: got c=%b a=%h want 0011/1234", ctrl1, alu_a1);
      else passed++;
`endif
      sb.push_back(e);
      if1.req = 2'b00;
      repeat (2) @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (if1.done !== e.who || if1.result !== e.res || if1.ovf !== e.ovf || if1.err !== e.err)
         $display("FAIL opchk_done: got done=%b res=%h ovf=%b err=%b want %b/%h/%b/%b",
                  if1.done, if1.result, if1.ovf, if1.err, e.who, e.res, e.ovf, e.err);
      else passed++;
      @(negedge clk);
      if1.req = 2'b01; if1.op0 = 4'b1100; if1.a0 = 16'h0F0F; if1.b0 = 16'hF0F0;
      @(negedge clk);
      checks++;
      if (if1.gnt !== 2'b01 || ctrl1 !== 4'b1100) $display("FAIL nor_gnt: got gnt=%b c=%b want 01/1100", if1.gnt, ctrl1);
      else passed++;
      e.who = 2'b01; e.res = 16'h0000; e.ovf = 1'b0; e.err = 1'b0;
      sb.push_back(e);
      if1.req = 2'b00;
      repeat (2) @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (if1.done !== e.who || if1.result !== e.res || if1.err !== e.err)
         $display("FAIL nor_done: got done=%b res=%h err=%b want %b/%h/%b", if1.done, if1.result, if1.err, e.who, e.res, e.err);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_add_ovf();
      test_round_robin();
      test_lat3();
      test_sub_drop();
      test_opcheck();
      checks++;
      if (sb.size() !== 0) $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
